// File: rtl/io_port_pkg.sv
// Shared register map and bit positions for the memory-mapped I/O port responder.
package io_port_pkg;

  // Word offsets decoded from Address[3:2]
  typedef enum logic [1:0] {
    OFS_DATA_OUT = 2'd0,
    OFS_DATA_IN  = 2'd1,
    OFS_STATUS   = 2'd2,
    OFS_CTRL     = 2'd3
  } reg_ofs_e;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_IN_CHG    = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

  localparam logic CTRL_EN_RST = 1'b1;

endpackage

// File: rtl/io_port_responder_fifo.sv
// Small synchronous FIFO with flush; head is presented combinationally and reads 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // A pop frees the slot the push lands in, so full+push+pop is legal.
  assign w_pop  = i_pop && !o_empty && !i_flush;
  assign w_push = i_push && !i_flush && (!o_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: store-fed output FIFO with valid/ready drain, synchronized input
// port with change flag, and status/control registers in a 16-byte window.
module io_port_responder
  import io_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          IN_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic [31:0]         ReadData,
  output logic                Hit,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                PortOutValid,
  input  logic                PortOutReady
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reg_ofs_e            w_sel;
  logic                w_wr, w_rd, w_push, w_pop, w_flush;
  logic                w_full, w_empty;
  logic [CW-1:0]       w_count;
  logic [31:0]         w_status;
  logic                w_unused_addr;

  logic [31:0]         r_last_out;
  logic                r_ovf, r_in_chg, r_en;
  logic [IN_WIDTH-1:0] r_sync1, r_sync2, r_prev;

  assign Hit           = (Address[31:4] == BASE_ADDR[31:4]);
  assign w_sel         = reg_ofs_e'(Address[3:2]);
  assign w_unused_addr = ^Address[1:0];
  assign w_wr          = Hit && MemWrite;
  assign w_rd          = Hit && MemRead;
  assign w_push        = w_wr && (w_sel == OFS_DATA_OUT);
  assign w_flush       = w_wr && (w_sel == OFS_CTRL) && WriteData[CTRL_FLUSH];

  // EN only gates the handshake; queued words stay put while disabled.
  assign PortOutValid = !w_empty && r_en;
  assign w_pop        = PortOutValid && PortOutReady;

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (WriteData),
    .o_head  (PortOut),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_out <= '0;
      r_ovf      <= 1'b0;
      r_in_chg   <= 1'b0;
      r_en       <= CTRL_EN_RST;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
    end else begin
      if (w_push) begin
        if (!w_full || w_pop) r_last_out <= WriteData;
        else                  r_ovf      <= 1'b1;
      end else if (w_wr && (w_sel == OFS_STATUS) && WriteData[ST_OVF]) begin
        r_ovf <= 1'b0;
      end
      if (w_wr && (w_sel == OFS_CTRL)) r_en <= WriteData[CTRL_EN];
      r_sync1 <= PortIn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      // A fresh change outranks the clear from a coincident DATA_IN read.
      if (r_sync2 != r_prev)                  r_in_chg <= 1'b1;
      else if (w_rd && (w_sel == OFS_DATA_IN)) r_in_chg <= 1'b0;
    end
  end

  always_comb begin
    w_status = '0;
    w_status[ST_EMPTY]  = w_empty;
    w_status[ST_FULL]   = w_full;
    w_status[ST_IN_CHG] = r_in_chg;
    w_status[ST_OVF]    = r_ovf;
    w_status[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(w_count);
  end

  always_comb begin
    ReadData = '0;
    if (w_rd) begin
      case (w_sel)
        OFS_DATA_OUT: ReadData = r_last_out;
        OFS_DATA_IN:  ReadData = 32'(r_sync2);
        OFS_STATUS:   ReadData = w_status;
        OFS_CTRL:     ReadData[CTRL_EN] = r_en;
        default:      ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: fixed vector table, directed corner sequences, then random traffic,
// every cycle also compared against a queue-based reference model.
module tb_io_port_responder;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = '0, WriteData = '0;
  logic        MemWrite = 1'b0, MemRead = 1'b0, PortOutReady = 1'b0;
  logic [7:0]  PortIn = '0;
  logic [31:0] ReadData, PortOut;
  logic        Hit, PortOutValid;

  always #5 clk = ~clk;

  io_port_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .IN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Hit(Hit),
    .PortIn(PortIn), .PortOut(PortOut), .PortOutValid(PortOutValid),
    .PortOutReady(PortOutReady)
  );

  int nvec = 0, nerr = 0;

  // Reference model: queue of pending words plus a 3-deep history of sampled PortIn.
  logic [31:0] mq[$];
  logic [31:0] m_last;
  logic        m_ovf, m_inchg, m_en;
  logic [7:0]  m_s1, m_s2, m_prev;

  task automatic model_reset();
    mq.delete();
    m_last = '0; m_ovf = 1'b0; m_inchg = 1'b0; m_en = 1'b1;
    m_s1 = '0; m_s2 = '0; m_prev = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic re);
    logic [31:0] r;
    r = '0;
    if (a[31:4] == BASE[31:4] && re) begin
      case (a[3:2])
        2'd0: r = m_last;
        2'd1: r = {24'h0, m_s2};
        2'd2: r = {24'h0, 4'(mq.size()), m_ovf, m_inchg,
                   (mq.size() == DEPTH), (mq.size() == 0)};
        default: r = {31'h0, m_en};
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one bus cycle, check against the model before the edge, then advance the model.
  task automatic apply(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic re, input logic rdy,
                       output logic [31:0] rd, output logic vld, output logic [31:0] po);
    logic hit_m, pop, wr;
    Address = a; WriteData = wd; MemWrite = we; MemRead = re; PortOutReady = rdy;
    #1;
    hit_m = (a[31:4] == BASE[31:4]);
    chk("model_hit", 32'(Hit), 32'(hit_m));
    chk("model_rdata", ReadData, m_read(a, re));
    chk("model_valid", 32'(PortOutValid), 32'(mq.size() > 0 && m_en));
    chk("model_portout", PortOut, (mq.size() > 0) ? mq[0] : 32'h0);
    rd = ReadData; vld = PortOutValid; po = PortOut;
    @(posedge clk);
    pop = (mq.size() > 0) && m_en && rdy;
    wr  = hit_m && we;
    if (wr && a[3:2] == 2'd3 && wd[1]) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (wr && a[3:2] == 2'd0) begin
        if (mq.size() < DEPTH) begin mq.push_back(wd); m_last = wd; end
        else m_ovf = 1'b1;
      end
    end
    if (wr && a[3:2] == 2'd2 && wd[3]) m_ovf = 1'b0;
    if (wr && a[3:2] == 2'd3) m_en = wd[0];
    if (m_s2 != m_prev) m_inchg = 1'b1;
    else if (hit_m && re && a[3:2] == 2'd1) m_inchg = 1'b0;
    m_prev = m_s2; m_s2 = m_s1; m_s1 = PortIn;
    #1;
  endtask

  logic [31:0] t_rd, t_po;
  logic        t_v;

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input logic rdy);
    apply(a, d, 1'b1, 1'b0, rdy, t_rd, t_v, t_po);
  endtask

  task automatic rd_reg(input logic [31:0] a, input logic rdy);
    apply(a, 32'h0, 1'b0, 1'b1, rdy, t_rd, t_v, t_po);
  endtask

  typedef struct {
    logic [31:0] a, wd;
    logic        we, re, rdy;
    logic        e_hit;
    logic [31:0] e_rd;
    logic        e_vld;
    logic [31:0] e_po;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [31:0] a, input logic [31:0] wd, input logic we,
                     input logic re, input logic rdy, input logic e_hit,
                     input logic [31:0] e_rd, input logic e_vld, input logic [31:0] e_po);
    vec_t v;
    v.a = a; v.wd = wd; v.we = we; v.re = re; v.rdy = rdy;
    v.e_hit = e_hit; v.e_rd = e_rd; v.e_vld = e_vld; v.e_po = e_po;
    tbl.push_back(v);
  endtask

  logic [31:0] ra, rwd;
  logic [31:0] exp3 [4];

  initial begin
    // Single store drains next cycle; then fill past depth, drain, clear OVF; out-of-window access.
    add(BASE+32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0);
    add(BASE+32'h8, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h10,       1'b1, 32'hDEADBEEF);
    add(BASE+32'h8, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h01,       1'b0, 32'h0);
    add(BASE+32'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
    add(BASE+32'h0, 32'h1,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0);
    add(BASE+32'h0, 32'h2,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 32'h1);
    add(BASE+32'h0, 32'h3,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 32'h1);
    add(BASE+32'h0, 32'h4,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 32'h1);
    add(BASE+32'h0, 32'h5,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 32'h1);
    add(BASE+32'h8, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h4A,       1'b1, 32'h1);
    add(BASE+32'h0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h4,        1'b1, 32'h1);
    add(BASE+32'h8, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h4A,       1'b1, 32'h1);
    add(BASE+32'h8, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h38,       1'b1, 32'h2);
    add(BASE+32'h8, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h28,       1'b1, 32'h3);
    add(BASE+32'h8, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h18,       1'b1, 32'h4);
    add(BASE+32'h8, 32'h8,        1'b1, 1'b1, 1'b1, 1'b1, 32'h09,       1'b0, 32'h0);
    add(BASE+32'hB, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h01,       1'b0, 32'h0);
    add(32'h1234_5670, 32'h0,     1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0);
    add(32'hFFFE_0000, 32'h7,     1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0);
    add(BASE+32'h8, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h01,       1'b0, 32'h0);

    model_reset();
    #3;
    chk("rst_valid", 32'(PortOutValid), 32'h0);
    chk("rst_portout", PortOut, 32'h0);
    #9 reset = 1'b1;
    @(posedge clk); #1;

    rd_reg(BASE+32'hC, 1'b0);
    chk("rst_ctrl", t_rd, 32'h1);

    foreach (tbl[i]) begin
      apply(tbl[i].a, tbl[i].wd, tbl[i].we, tbl[i].re, tbl[i].rdy, t_rd, t_v, t_po);
      chk($sformatf("tbl%0d_hit", i), 32'(Hit), 32'(tbl[i].e_hit));
      chk($sformatf("tbl%0d_rdata", i), t_rd, tbl[i].e_rd);
      chk($sformatf("tbl%0d_valid", i), 32'(t_v), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_portout", i), t_po, tbl[i].e_po);
    end

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) wr_reg(BASE, 32'(10 + i), 1'b0);
    wr_reg(BASE, 32'd9, 1'b1);
    chk("full_pp_head", t_po, 32'd10);
    rd_reg(BASE+32'h8, 1'b0);
    chk("full_pp_status", t_rd, 32'h42);
    exp3[0] = 32'd11; exp3[1] = 32'd12; exp3[2] = 32'd13; exp3[3] = 32'd9;
    for (int i = 0; i < 4; i++) begin
      rd_reg(BASE+32'h8, 1'b1);
      chk($sformatf("full_pp_drain%0d", i), t_po, exp3[i]);
    end

    // PortIn change detect, read-clear, and set-wins on coincident read
    PortIn = 8'hA5;
    for (int i = 0; i < 3; i++) rd_reg(32'h0, 1'b0);
    rd_reg(BASE+32'h8, 1'b0);
    chk("inchg_set", t_rd, 32'h05);
    rd_reg(BASE+32'h4, 1'b0);
    chk("datain", t_rd, 32'h0000_00A5);
    rd_reg(BASE+32'h8, 1'b0);
    chk("inchg_clr", t_rd, 32'h01);
    PortIn = 8'h5A;
    rd_reg(32'h0, 1'b0);
    rd_reg(32'h0, 1'b0);
    rd_reg(BASE+32'h4, 1'b0);
    chk("datain_coinc", t_rd, 32'h0000_005A);
    rd_reg(BASE+32'h8, 1'b0);
    chk("inchg_setwins", t_rd, 32'h05);
    rd_reg(BASE+32'h4, 1'b0);
    rd_reg(BASE+32'h8, 1'b0);
    chk("inchg_clr2", t_rd, 32'h01);

    // EN gating and flush
    wr_reg(BASE, 32'h21, 1'b0);
    wr_reg(BASE, 32'h22, 1'b0);
    wr_reg(BASE+32'hC, 32'h0, 1'b0);
    rd_reg(BASE+32'h8, 1'b1);
    chk("en0_valid", 32'(t_v), 32'h0);
    chk("en0_head", t_po, 32'h21);
    rd_reg(BASE+32'h8, 1'b1);
    chk("en0_count", t_rd, 32'h20);
    wr_reg(BASE+32'hC, 32'h1, 1'b0);
    rd_reg(BASE+32'h8, 1'b1);
    chk("en1_valid", 32'(t_v), 32'h1);
    chk("en1_head0", t_po, 32'h21);
    rd_reg(BASE+32'h8, 1'b1);
    chk("en1_head1", t_po, 32'h22);
    wr_reg(BASE, 32'h31, 1'b0);
    wr_reg(BASE, 32'h32, 1'b0);
    wr_reg(BASE+32'hC, 32'h3, 1'b0);
    rd_reg(BASE+32'h8, 1'b0);
    chk("flush_status", t_rd, 32'h01);
    rd_reg(BASE+32'hC, 1'b0);
    chk("flush_ctrl", t_rd, 32'h1);

    // Asynchronous reset in the middle of a drain
    wr_reg(BASE, 32'h41, 1'b0);
    wr_reg(BASE, 32'h42, 1'b0);
    wr_reg(BASE, 32'h43, 1'b0);
    rd_reg(32'h0, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(PortOutValid), 32'h0);
    chk("async_rst_portout", PortOut, 32'h0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    rd_reg(BASE+32'h8, 1'b0);
    chk("post_rst_status", t_rd, 32'h01);
    rd_reg(BASE+32'hC, 1'b0);
    chk("post_rst_ctrl", t_rd, 32'h1);
    rd_reg(BASE+32'h0, 1'b0);
    chk("post_rst_last", t_rd, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 8) ra = BASE | 32'($urandom_range(0, 15));
      else ra = $urandom;
      rwd = $urandom;
      if (ra[3:2] == 2'd3) begin
        if ($urandom_range(0, 3) != 0) rwd[1] = 1'b0;
        if ($urandom_range(0, 3) != 0) rwd[0] = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) PortIn = 8'($urandom);
      apply(ra, rwd, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
            ((i % 64) < 32) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            t_rd, t_v, t_po);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
